// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: opcode encodings,
// FSM state encoding and the default datapath width.
package hilo_muldiv_unit_pkg;

    localparam int WIDTH_DEF = 32;

    // ALUCtl encodings produced by ALU control decode
    localparam logic [4:0] OP_MFHI  = 5'b10000;
    localparam logic [4:0] OP_MTHI  = 5'b10001;
    localparam logic [4:0] OP_MFLO  = 5'b10010;
    localparam logic [4:0] OP_MTLO  = 5'b10011;
    localparam logic [4:0] OP_MULT  = 5'b00101;
    localparam logic [4:0] OP_MULTU = 5'b01100;
    localparam logic [4:0] OP_MADD  = 5'b11010;
    localparam logic [4:0] OP_MSUB  = 5'b01101;
    localparam logic [4:0] OP_MUL   = 5'b11000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// EX-stage request/response bundle for the HI/LO unit. Dbg_State mirrors the
// unit's FSM state for observation only.
//
// Handshake: the requester holds Start and the instruction fields stable until
// Done; Start is only sampled while Busy is low, Flush kills any request or
// operation in flight, and Done is a single-cycle completion pulse.
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = hilo_muldiv_unit_pkg::WIDTH_DEF
);
    import hilo_muldiv_unit_pkg::*;

    logic             Start;
    logic             Flush;
    logic [4:0]       ALUCtl;
    logic             HiLoWrite;
    logic             MultBit;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    state_t           Dbg_State;

    modport master (
        output Start, Flush, ALUCtl, HiLoWrite, MultBit, A, B,
        input  Busy, Done, Result, Hi, Lo, Dbg_State
    );

    modport slave (
        input  Start, Flush, ALUCtl, HiLoWrite, MultBit, A, B,
        output Busy, Done, Result, Hi, Lo, Dbg_State
    );

endinterface

// File: rtl/hilo_muldiv_unit_mult_iter_core.sv
// Unsigned WIDTH x WIDTH radix-2 shift-add multiplier, one bit per clock.
// o_done is high during the final iteration cycle; o_product is complete
// after the following edge and holds until the next start.
module hilo_muldiv_unit_mult_iter_core #(
    parameter int WIDTH = hilo_muldiv_unit_pkg::WIDTH_DEF
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_run;

    assign o_done    = r_run && (r_cnt == LAST);
    assign o_product = r_acc;

    // Load operands on start, then add the shifted multiplicand per set multiplier bit
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
        end else if (i_abort) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_cnt    <= '0;
            r_run    <= 1'b1;
        end else if (r_run) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (o_done) begin
                r_run <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Execution-stage HI/LO register file with an iterative multiply/accumulate
// engine. Single-cycle moves complete immediately; multiply-class ops run
// WIDTH iterations plus one sign fix-up/commit cycle with Busy raised.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic                Clk,
    input logic                Rst_n,
    hilo_muldiv_unit_if.slave  bus
);
    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic [4:0]       r_op;
    logic             r_hlw;
    logic             r_gpr;
    logic             r_neg;

    logic               w_is_single;
    logic               w_is_mc;
    logic               w_is_signed;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_core_start;
    logic               w_core_abort;
    logic               w_core_done;
    logic [2*WIDTH-1:0] w_core_prod;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_accept_single;
    logic               w_commit;

    assign w_is_single = (bus.ALUCtl == OP_MFHI) || (bus.ALUCtl == OP_MTHI) ||
                         (bus.ALUCtl == OP_MFLO) || (bus.ALUCtl == OP_MTLO);
    assign w_is_mc     = (bus.ALUCtl == OP_MULT) || (bus.ALUCtl == OP_MULTU) ||
                         (bus.ALUCtl == OP_MADD) || (bus.ALUCtl == OP_MSUB)  ||
                         (bus.ALUCtl == OP_MUL);
    assign w_is_signed = w_is_mc && (bus.ALUCtl != OP_MULTU);

    // Magnitudes for the unsigned core; -(most negative) wraps to itself, which
    // is exactly the correct unsigned magnitude.
    assign w_abs_a = (w_is_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign w_abs_b = (w_is_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    assign w_prod = r_neg ? -w_core_prod : w_core_prod;

    hilo_muldiv_unit_mult_iter_core #(.WIDTH(WIDTH)) u_core (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .i_start   (w_core_start),
        .i_abort   (w_core_abort),
        .i_a       (w_abs_a),
        .i_b       (w_abs_b),
        .o_done    (w_core_done),
        .o_product (w_core_prod)
    );

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control strobes; Flush always wins over Start and commit
    always_comb begin
        w_state_next    = r_state;
        w_core_start    = 1'b0;
        w_core_abort    = 1'b0;
        w_accept_single = 1'b0;
        w_commit        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.Start && !bus.Flush) begin
                    if (w_is_mc) begin
                        w_core_start = 1'b1;
                        w_state_next = ST_CALC;
                    end else if (w_is_single) begin
                        w_accept_single = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                if (bus.Flush) begin
                    w_core_abort = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_core_done) begin
                    w_state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                w_state_next = ST_IDLE;
                if (!bus.Flush) begin
                    w_commit = 1'b1;
                end
            end
            default: begin
                w_core_abort = 1'b1;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // HI/LO/Result state, latched op context and the Done pulse
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_op     <= '0;
            r_hlw    <= 1'b0;
            r_gpr    <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_core_start) begin
                r_op  <= bus.ALUCtl;
                r_hlw <= bus.HiLoWrite;
                r_gpr <= (bus.ALUCtl == OP_MUL) || bus.MultBit;
                r_neg <= w_is_signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            end
            if (w_accept_single) begin
                r_done <= 1'b1;
                case (bus.ALUCtl)
                    OP_MTHI: if (bus.HiLoWrite) r_hi <= bus.A;
                    OP_MTLO: if (bus.HiLoWrite) r_lo <= bus.A;
                    OP_MFHI: r_result <= r_hi;
                    OP_MFLO: r_result <= r_lo;
                    default: ;
                endcase
            end
            if (w_commit) begin
                r_done <= 1'b1;
                if (r_gpr) begin
                    r_result <= w_prod[WIDTH-1:0];
                end else if (r_hlw) begin
                    case (r_op)
                        OP_MADD: {r_hi, r_lo} <= {r_hi, r_lo} + w_prod;
                        OP_MSUB: {r_hi, r_lo} <= {r_hi, r_lo} - w_prod;
                        default: {r_hi, r_lo} <= w_prod;
                    endcase
                end
            end
        end
    end

    assign bus.Busy      = (r_state != ST_IDLE);
    assign bus.Done      = r_done;
    assign bus.Result    = r_result;
    assign bus.Hi        = r_hi;
    assign bus.Lo        = r_lo;
    assign bus.Dbg_State = r_state;

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execution-stage HI/LO register file and iterative multiply/accumulate engine.
- Consumes the ALU-control encoding (ALUCtl, HiLoWrite, MultBit) produced by ALU control decode.
- Executes mult, multu, madd, msub, mul, mthi, mtlo, mfhi and mflo.
- Holds HI/LO state and raises Busy so the hazard unit can stall the pipeline during multi-cycle operations.

Parameters:
- WIDTH, 32, operand, HI and LO width; multiply latency scales with it.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request qualifier from EX, sampled in IDLE only.
- Flush  input  1  pipeline kill; aborts the in-flight operation.
- ALUCtl  input  5  operation code.
- HiLoWrite  input  1  permits commit to HI/LO.
- MultBit  input  1  marks mul (32-bit result to the GPR path).
- A  input  WIDTH  rs operand.
- B  input  WIDTH  rt operand.
- Busy  output  1  high while a multiply-class op is in flight.
- Done  output  1  one-cycle completion pulse.
- Result  output  WIDTH  GPR-bound value for mul, mfhi, mflo.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.

Behaviour:
- Reset (Rst_n low, asynchronous): Hi=0, Lo=0, Result=0, Busy=0, Done=0, state=IDLE, counter=0. Reset asserted mid-operation discards the operation.
- Recognised ALUCtl codes:
  - mfhi 10000, mthi 10001, mflo 10010, mtlo 10011.
  - mult 00101, multu 01100, madd 11010, msub 01101, mul 11000.
  - Start with any other code is ignored: no Done, no state change.
- States:
  - IDLE: Busy=0.
  - CALC: 32 iterations; counter runs 0..WIDTH-1.
  - FIN: sign fix-up and commit.
- Single-cycle ops (IDLE, Start=1, accepted at edge E):
  - mthi: Hi<=A at E when HiLoWrite=1.
  - mtlo: Lo<=A at E when HiLoWrite=1.
  - mfhi: Result<=Hi at E.
  - mflo: Result<=Lo at E.
  - Done=1 for the cycle after E. Busy stays 0.
- Multiply-class ops (accepted at edge E0):
  - At E0: latch |A|, |B| (signed ops) or A, B raw (multu), the sign flag, the opcode and HiLoWrite; go to CALC.
  - Edges E1..E32: radix-2 shift-add, one bit per edge. At the last iteration go to FIN.
  - Edge E33: negate the 64-bit product if signs differ (signed ops), commit, go to IDLE, Done<=1.
  - Busy=1 during the WIDTH+1 cycles from E0 to E33.
  - Done is high in the cycle after E33, with Busy already 0.
- Commit rules at FIN:
  - mult, multu: {Hi,Lo}<=product.
  - madd: {Hi,Lo}<={Hi,Lo}+product, modulo 2^64.
  - msub: {Hi,Lo}<={Hi,Lo}-product, modulo 2^64.
  - mul: Result<=product[WIDTH-1:0]; Hi and Lo stay unchanged.
  - HI/LO-writing op with HiLoWrite=0: computed but Hi and Lo not written; Done still pulses.
- Arithmetic edge cases:
  - |0x80000000| is treated as unsigned 0x80000000; the product stays correct.
  - Operand 0 produces product 0 through the full latency; there is no early exit.
- Handshake and flush:
  - Start while Busy=1 is ignored. Upstream holds the instruction until Done.
  - Flush=1 in CALC or FIN: next edge goes to IDLE, Busy=0, no Done; Hi, Lo and Result unchanged.
  - Flush together with Start in IDLE: Flush wins and nothing is accepted.
- Result holds its value until the next mul, mfhi or mflo commit.
- Hi and Lo are register outputs, never combinational from A or B.

Decomposition:
- Shared package/header holds: ALUCtl encoding constants (the nine codes above), state encoding (IDLE, CALC, FIN), and the WIDTH default.
- Sub-module mult_iter_core:
  - Unsigned WIDTH x WIDTH shift-add multiplier.
  - Ports: start, abort, done, 2*WIDTH product.
  - Sign handling, accumulate and HI/LO commit stay in the top level.

Test Plan:
- Reset: drive Rst_n low asynchronously mid-cycle -> Hi=Lo=Result=0, Busy=0, Done=0 immediately. Repeat during CALC at counter 15 -> same; no Done after release.
- mult A=0xFFFFFFFE, B=0x00000003, HiLoWrite=1 -> Busy for 33 cycles, then a Done pulse -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
- multu A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Then mult with the same operands -> Hi=0x00000000, Lo=0x00000001.
- Accumulate sequence:
  - mthi 0x00000001, then mtlo 0xFFFFFFFF -> each Done after 1 cycle, Busy=0.
  - madd A=1, B=1 -> Hi=0x00000002, Lo=0x00000000.
  - msub A=1, B=1 -> Hi=0x00000001, Lo=0xFFFFFFFF.
- mul A=0xFFFFFFF9 (-7), B=6, MultBit=1 -> Result=0xFFFFFFD6 with Hi/Lo unchanged. Then mflo -> Result=Lo one cycle later with Done. Start with ALUCtl=00010 -> no Done.
- mult A=5, B=7 with Flush at cycle 10 of CALC -> Busy=0 next cycle, no Done, Hi/Lo keep prior values. Start during Busy -> ignored; the original op still completes with the correct product.
